// File: rtl/encrypt_iter.sv
// Iterative DES encryptor: one round and one key-schedule stage reused
// for 16 cycles, with a 4-phase req/ack handshake.

module des_perm #(
  parameter int WI = 64,
  parameter int WO = 64,
  parameter logic [WO*8-1:0] T = '0
) (
  input  logic [WI-1:0] i,
  output logic [WO-1:0] o
);
  // Dropped input bits (e.g. key parity) are folded here.
  logic unused;
  assign unused = ^i;

  for (genvar j = 0; j < WO; j++) begin : g_bit
    localparam int S = int'(T[(WO-1-j)*8 +: 8]);
    assign o[WO-1-j] = i[WI-S];
  end
endmodule

module perm_IP (
  input  logic [63:0] i,
  output logic [63:0] o
);
  des_perm #(.WI(64), .WO(64), .T({
    8'd58,8'd50,8'd42,8'd34,8'd26,8'd18,8'd10,8'd2,
    8'd60,8'd52,8'd44,8'd36,8'd28,8'd20,8'd12,8'd4,
    8'd62,8'd54,8'd46,8'd38,8'd30,8'd22,8'd14,8'd6,
    8'd64,8'd56,8'd48,8'd40,8'd32,8'd24,8'd16,8'd8,
    8'd57,8'd49,8'd41,8'd33,8'd25,8'd17,8'd9,8'd1,
    8'd59,8'd51,8'd43,8'd35,8'd27,8'd19,8'd11,8'd3,
    8'd61,8'd53,8'd45,8'd37,8'd29,8'd21,8'd13,8'd5,
    8'd63,8'd55,8'd47,8'd39,8'd31,8'd23,8'd15,8'd7
  })) u_p (.i(i), .o(o));
endmodule

module perm_FP (
  input  logic [63:0] i,
  output logic [63:0] o
);
  des_perm #(.WI(64), .WO(64), .T({
    8'd40,8'd8,8'd48,8'd16,8'd56,8'd24,8'd64,8'd32,
    8'd39,8'd7,8'd47,8'd15,8'd55,8'd23,8'd63,8'd31,
    8'd38,8'd6,8'd46,8'd14,8'd54,8'd22,8'd62,8'd30,
    8'd37,8'd5,8'd45,8'd13,8'd53,8'd21,8'd61,8'd29,
    8'd36,8'd4,8'd44,8'd12,8'd52,8'd20,8'd60,8'd28,
    8'd35,8'd3,8'd43,8'd11,8'd51,8'd19,8'd59,8'd27,
    8'd34,8'd2,8'd42,8'd10,8'd50,8'd18,8'd58,8'd26,
    8'd33,8'd1,8'd41,8'd9,8'd49,8'd17,8'd57,8'd25
  })) u_p (.i(i), .o(o));
endmodule

module perm_PC1 (
  input  logic [63:0] i,
  output logic [55:0] o
);
  des_perm #(.WI(64), .WO(56), .T({
    8'd57,8'd49,8'd41,8'd33,8'd25,8'd17,8'd9,
    8'd1,8'd58,8'd50,8'd42,8'd34,8'd26,8'd18,
    8'd10,8'd2,8'd59,8'd51,8'd43,8'd35,8'd27,
    8'd19,8'd11,8'd3,8'd60,8'd52,8'd44,8'd36,
    8'd63,8'd55,8'd47,8'd39,8'd31,8'd23,8'd15,
    8'd7,8'd62,8'd54,8'd46,8'd38,8'd30,8'd22,
    8'd14,8'd6,8'd61,8'd53,8'd45,8'd37,8'd29,
    8'd21,8'd13,8'd5,8'd28,8'd20,8'd12,8'd4
  })) u_p (.i(i), .o(o));
endmodule

module perm_PC2 (
  input  logic [55:0] i,
  output logic [47:0] o
);
  des_perm #(.WI(56), .WO(48), .T({
    8'd14,8'd17,8'd11,8'd24,8'd1,8'd5,
    8'd3,8'd28,8'd15,8'd6,8'd21,8'd10,
    8'd23,8'd19,8'd12,8'd4,8'd26,8'd8,
    8'd16,8'd7,8'd27,8'd20,8'd13,8'd2,
    8'd41,8'd52,8'd31,8'd37,8'd47,8'd55,
    8'd30,8'd40,8'd51,8'd45,8'd33,8'd48,
    8'd44,8'd49,8'd39,8'd56,8'd34,8'd53,
    8'd46,8'd42,8'd50,8'd36,8'd29,8'd32
  })) u_p (.i(i), .o(o));
endmodule

module perm_E (
  input  logic [31:0] i,
  output logic [47:0] o
);
  des_perm #(.WI(32), .WO(48), .T({
    8'd32,8'd1,8'd2,8'd3,8'd4,8'd5,
    8'd4,8'd5,8'd6,8'd7,8'd8,8'd9,
    8'd8,8'd9,8'd10,8'd11,8'd12,8'd13,
    8'd12,8'd13,8'd14,8'd15,8'd16,8'd17,
    8'd16,8'd17,8'd18,8'd19,8'd20,8'd21,
    8'd20,8'd21,8'd22,8'd23,8'd24,8'd25,
    8'd24,8'd25,8'd26,8'd27,8'd28,8'd29,
    8'd28,8'd29,8'd30,8'd31,8'd32,8'd1
  })) u_p (.i(i), .o(o));
endmodule

module perm_P (
  input  logic [31:0] i,
  output logic [31:0] o
);
  des_perm #(.WI(32), .WO(32), .T({
    8'd16,8'd7,8'd20,8'd21,8'd29,8'd12,8'd28,8'd17,
    8'd1,8'd15,8'd23,8'd26,8'd5,8'd18,8'd31,8'd10,
    8'd2,8'd8,8'd24,8'd14,8'd32,8'd27,8'd3,8'd9,
    8'd19,8'd13,8'd30,8'd6,8'd22,8'd11,8'd4,8'd25
  })) u_p (.i(i), .o(o));
endmodule

module split_2 (
  input  logic [63:0] x,
  output logic [31:0] l,
  output logic [31:0] r
);
  assign {l, r} = x;
endmodule

module merge_2 (
  input  logic [31:0] l,
  input  logic [31:0] r,
  output logic [63:0] x
);
  assign x = {l, r};
endmodule

module key_schedule (
  input  logic [55:0] k,
  input  logic [3:0]  i,
  output logic [55:0] kn,
  output logic [47:0] sk
);
  logic        one;
  logic [27:0] c0, d0, c1, d1;

  // Rounds 1, 2, 9 and 16 rotate by one, all others by two.
  assign one = (i == 4'd0) || (i == 4'd1) ||
               (i == 4'd8) || (i == 4'd15);
  assign {c0, d0} = k;
  assign c1 = one ? {c0[26:0], c0[27]} : {c0[25:0], c0[27:26]};
  assign d1 = one ? {d0[26:0], d0[27]} : {d0[25:0], d0[27:26]};
  assign kn = {c1, d1};

  perm_PC2 u_pc2 (.i(kn), .o(sk));
endmodule

module round (
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [47:0] sk,
  output logic [31:0] lo,
  output logic [31:0] ro
);
  localparam logic [2047:0] SB = {
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
  };

  logic [47:0] e, x;
  logic [31:0] s, p;

  perm_E u_e (.i(r), .o(e));
  assign x = e ^ sk;

  // Row from outer bits, column from the inner four.
  always_comb begin
    s = '0;
    for (int j = 0; j < 8; j++) begin
      int ix;
      ix = int'({x[47-6*j], x[42-6*j], x[46-6*j -: 4]});
      s[31-4*j -: 4] = SB[2047-256*j-4*ix -: 4];
    end
  end

  perm_P u_p (.i(s), .o(p));

  assign lo = r;
  assign ro = l ^ p;
endmodule

module encrypt_iter #(
  parameter int N_K = 64,
  parameter int N_B = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  output logic           ack,
  input  logic [N_K-1:0] k,
  input  logic [N_B-1:0] m,
  output logic [N_B-1:0] c
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, nxt;
  logic [31:0] l, r, ip_l, ip_r, lo, ro;
  logic [55:0] kr, kn, pc1;
  logic [47:0] sk;
  logic [3:0]  ctr;
  logic [63:0] ipm, pre, fp;

  perm_IP      u_ip  (.i(m), .o(ipm));
  split_2      u_sp  (.x(ipm), .l(ip_l), .r(ip_r));
  perm_PC1     u_pc1 (.i(k), .o(pc1));
  key_schedule u_ks  (.k(kr), .i(ctr), .kn(kn), .sk(sk));
  round        u_rd  (.l(l), .r(r), .sk(sk), .lo(lo), .ro(ro));
  // Final halves are swapped before the inverse permutation.
  merge_2      u_mg  (.l(ro), .r(lo), .x(pre));
  perm_FP      u_fp  (.i(pre), .o(fp));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (req) nxt = RUN;
      RUN:     if (ctr == 4'd15) nxt = DONE;
      DONE:    if (!req) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l   <= '0;
      r   <= '0;
      kr  <= '0;
      ctr <= '0;
      c   <= '0;
    end else begin
      unique case (state)
        IDLE: if (req) begin
          l   <= ip_l;
          r   <= ip_r;
          kr  <= pc1;
          ctr <= '0;
        end
        RUN: begin
          l   <= lo;
          r   <= ro;
          kr  <= kn;
          ctr <= ctr + 4'd1;
          if (ctr == 4'd15) c <= fp;
        end
        default: ;
      endcase
    end
  end

  assign ack = (state == DONE);
endmodule

// File: tb/tb_encrypt_iter.sv
// Directed bench for encrypt_iter: known DES vectors, latency,
// handshake corner cases and mid-run reset.

module tb_encrypt_iter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        ack;
  logic [63:0] k, m, c;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] M1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] M2 = 64'h8787878787878787;
  localparam logic [63:0] C2 = 64'h0000000000000000;

  encrypt_iter #(.N_K(64), .N_B(64)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .k(k), .m(m), .c(c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Raise req, wait for ack (bounded), report latency and result.
  task automatic run_op(input string tag,
                        input logic [63:0] kk,
                        input logic [63:0] mm,
                        input bit scramble,
                        input int dropat,
                        input logic [63:0] exp);
    int n;
    n = 0;
    k = kk;
    m = mm;
    req = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (scramble) begin
        k = {$urandom, $urandom};
        m = {$urandom, $urandom};
      end
      if (n == dropat) req = 1'b0;
    end while (!ack && n < 40);
    chk({tag, "_ack"}, 64'(ack), 64'd1);
    chk({tag, "_lat"}, 64'(n - 1), 64'd16);
    chk({tag, "_c"}, c, exp);
  endtask

  task automatic drop(input string tag, input logic [63:0] exp);
    req = 1'b0;
    @(negedge clk);
    chk({tag, "_ackfall"}, 64'(ack), 64'd0);
    chk({tag, "_hold"}, c, exp);
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    k = '0;
    m = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_c", c, 64'd0);
    end

    run_op("v1", K1, M1, 1'b0, 0, C1);
    drop("v1", C1);

    run_op("v2", K2, M2, 1'b0, 0, C2);
    drop("v2", C2);
    run_op("v1b", K1, M1, 1'b0, 0, C1);
    drop("v1b", C1);

    run_op("scr", K1, M1, 1'b1, 0, C1);
    drop("scr", C1);

    // Reset during RUN, with req still high on the reset edge.
    k = K2;
    m = M2;
    req = 1'b1;
    repeat (9) @(negedge clk);
    chk("mid_ack", 64'(ack), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_ack", 64'(ack), 64'd0);
    chk("mrst_c", c, 64'd0);
    rst = 1'b0;
    run_op("post", K1, M1, 1'b0, 0, C1);
    drop("post", C1);

    // req dropped mid-run: single-cycle ack pulse, then restart.
    run_op("early", K2, M2, 1'b0, 5, C2);
    drop("early", C2);
    run_op("again", K1, M1, 1'b0, 0, C1);
    drop("again", C1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
